// File: rtl/switch_pkg.sv
// Shared constants and input-FSM state type for the 4-port byte-stream router.
package switch_pkg;
  localparam int DW         = 8;
  localparam int FIFO_DEPTH = 256;
  localparam int NUM_PORTS  = 4;

  typedef enum logic [1:0] {
    IDLE,
    FWD,
    DROP
  } fsm_state_t;
endpackage

// File: rtl/switch_port_fifo.sv
// Single-clock output FIFO for one router port.
// The popped byte is registered onto dout and returns to zero when no pop occurs.
module switch_port_fifo
  import switch_pkg::*;
#(
  parameter int DATA_W = DW,
  parameter int DEPTH  = FIFO_DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] COUNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] COUNT_ONE  = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [AW:0]       count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == COUNT_FULL);
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO can still take a byte when the same edge frees a slot.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      dout <= do_pop ? mem[rd_ptr] : '0;
      case ({do_push, do_pop})
        2'b10:   count <= count + COUNT_ONE;
        2'b01:   count <= count - COUNT_ONE;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/switch_4port.sv
// Four-port packet router: DA lookup against programmable port addresses,
// input framing FSM, and one output FIFO per port.
module switch_4port #(
  parameter int FIFO_DEPTH = switch_pkg::FIFO_DEPTH,
  parameter int DW         = switch_pkg::DW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          data_status,
  input  logic [DW-1:0] data,
  input  logic          mem_en,
  input  logic          mem_rd_wr,
  input  logic [1:0]    mem_add,
  input  logic [DW-1:0] mem_data,
  output logic [DW-1:0] port0,
  output logic [DW-1:0] port1,
  output logic [DW-1:0] port2,
  output logic [DW-1:0] port3,
  output logic          ready_0,
  output logic          ready_1,
  output logic          ready_2,
  output logic          ready_3,
  input  logic          read_0,
  input  logic          read_1,
  input  logic          read_2,
  input  logic          read_3
);

  import switch_pkg::NUM_PORTS;
  import switch_pkg::fsm_state_t;
  import switch_pkg::IDLE;
  import switch_pkg::FWD;
  import switch_pkg::DROP;

  localparam int PW = $clog2(NUM_PORTS);

  logic [DW-1:0]        addr_reg [NUM_PORTS];
  fsm_state_t           state;
  fsm_state_t           next_state;
  logic [PW-1:0]        dest;
  logic [PW-1:0]        next_dest;
  logic                 match_found;
  logic [PW-1:0]        match_idx;
  logic [NUM_PORTS-1:0] wr_req;
  logic [NUM_PORTS-1:0] read_vec;
  logic [NUM_PORTS-1:0] fifo_push;
  logic [NUM_PORTS-1:0] fifo_pop;
  logic [NUM_PORTS-1:0] fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [DW-1:0]        port_data [NUM_PORTS];

  assign read_vec = {read_3, read_2, read_1, read_0};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        addr_reg[i] <= '0;
      end
    end else if (mem_en && mem_rd_wr) begin
      addr_reg[mem_add] <= mem_data;
    end
  end

  // Scan from the top so the lowest matching index is the one left standing.
  always_comb begin
    match_found = 1'b0;
    match_idx   = '0;
    for (int i = NUM_PORTS - 1; i >= 0; i--) begin
      if (data == addr_reg[i]) begin
        match_found = 1'b1;
        match_idx   = PW'(i);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      dest  <= '0;
    end else begin
      state <= next_state;
      dest  <= next_dest;
    end
  end

  always_comb begin
    next_state = state;
    next_dest  = dest;
    wr_req     = '0;
    case (state)
      IDLE: begin
        if (data_status) begin
          if (match_found) begin
            wr_req[match_idx] = 1'b1;
            next_dest         = match_idx;
            next_state        = FWD;
          end else begin
            next_state = DROP;
          end
        end
      end
      FWD: begin
        if (data_status) begin
          wr_req[dest] = 1'b1;
        end else begin
          next_state = IDLE;
        end
      end
      DROP: begin
        if (!data_status) begin
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_port
    assign fifo_pop[g]  = read_vec[g] && !fifo_empty[g];
    assign fifo_push[g] = wr_req[g] && (!fifo_full[g] || fifo_pop[g]);

    switch_port_fifo #(
      .DATA_W (DW),
      .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (fifo_push[g]),
      .din   (data),
      .pop   (fifo_pop[g]),
      .dout  (port_data[g]),
      .full  (fifo_full[g]),
      .empty (fifo_empty[g])
    );
  end

  assign port0   = port_data[0];
  assign port1   = port_data[1];
  assign port2   = port_data[2];
  assign port3   = port_data[3];
  assign ready_0 = !fifo_empty[0];
  assign ready_1 = !fifo_empty[1];
  assign ready_2 = !fifo_empty[2];
  assign ready_3 = !fifo_empty[3];

endmodule

// File: tb/tb_switch_4port.sv
// Scoreboard bench for switch_4port: stimulus queues expected bytes per port,
// a negedge monitor pops and compares whenever a port presents a read byte.
module tb_switch_4port;
  import switch_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       data_status;
  logic [7:0] data;
  logic       mem_en;
  logic       mem_rd_wr;
  logic [1:0] mem_add;
  logic [7:0] mem_data;
  logic [7:0] port_vec [4];
  logic [3:0] rd_vec;
  logic [3:0] rdy_vec;
  logic       rdy0, rdy1, rdy2, rdy3;

  logic [7:0] exp_q [4][$];
  logic [7:0] pkt [$];
  logic [7:0] tb_addr [4];
  logic [7:0] mon_exp;
  logic [3:0] pending = '0;
  int         checks = 0;
  int         errors = 0;

  always #5 clk = ~clk;

  switch_4port dut (
    .clk         (clk),
    .reset       (reset),
    .data_status (data_status),
    .data        (data),
    .mem_en      (mem_en),
    .mem_rd_wr   (mem_rd_wr),
    .mem_add     (mem_add),
    .mem_data    (mem_data),
    .port0       (port_vec[0]),
    .port1       (port_vec[1]),
    .port2       (port_vec[2]),
    .port3       (port_vec[3]),
    .ready_0     (rdy0),
    .ready_1     (rdy1),
    .ready_2     (rdy2),
    .ready_3     (rdy3),
    .read_0      (rd_vec[0]),
    .read_1      (rd_vec[1]),
    .read_2      (rd_vec[2]),
    .read_3      (rd_vec[3])
  );

  assign rdy_vec = {rdy3, rdy2, rdy1, rdy0};

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, required);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int findDest(input logic [7:0] da);
    for (int i = 0; i < 4; i++) begin
      if (tb_addr[i] == da) return i;
    end
    return -1;
  endfunction

  task automatic cfgWrite(input logic [1:0] idx, input logic [7:0] val);
    mem_en    = 1'b1;
    mem_rd_wr = 1'b1;
    mem_add   = idx;
    mem_data  = val;
    tick();
    mem_en    = 1'b0;
    mem_rd_wr = 1'b0;
    tb_addr[idx] = val;
  endtask

  // Sends pkt framed by data_status, then one idle cycle.
  task automatic applyStimulus();
    int dest = -1;
    for (int i = 0; i < pkt.size(); i++) begin
      if (i == 0) dest = findDest(pkt[0]);
      data_status = 1'b1;
      data        = pkt[i];
      if (dest >= 0 && exp_q[dest].size() < FIFO_DEPTH) exp_q[dest].push_back(pkt[i]);
      tick();
    end
    data_status = 1'b0;
    data        = 8'h00;
    tick();
  endtask

  task automatic drainPorts(input logic [3:0] mask);
    int n = 0;
    rd_vec = mask;
    tick();
    while ((rdy_vec & mask) != 4'b0 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if ((rdy_vec & mask) != 4'b0) begin
      errors++;
      $display("[TB] FAIL drain_timeout actual=%b required=0000", rdy_vec & mask);
    end
    rd_vec = '0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) checkOutput($sformatf("port%0d_leftover", i), exp_q[i].size(), 0);
    end
  endtask

  always @(negedge clk) begin
    if (reset) begin
      pending = '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (pending[i]) begin
          if (exp_q[i].size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL port%0d_extra actual=%0h required=no_byte", i, port_vec[i]);
          end else begin
            mon_exp = exp_q[i].pop_front();
            checkOutput($sformatf("port%0d_byte", i), port_vec[i], mon_exp);
          end
        end else begin
          checkOutput($sformatf("port%0d_idle", i), port_vec[i], 8'h00);
        end
        pending[i] = rd_vec[i] & rdy_vec[i];
      end
    end
  end

  initial begin
    #600000;
    $display("[TB] FAIL watchdog actual=running required=finished");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    data_status = 1'b0;
    data = 8'h00;
    mem_en = 1'b0;
    mem_rd_wr = 1'b0;
    mem_add = 2'd0;
    mem_data = 8'h00;
    rd_vec = '0;
    for (int i = 0; i < 4; i++) tb_addr[i] = 8'h00;
    tick();
    tick();
    reset = 1'b0;
    tick();
    checkOutput("reset_ready", rdy_vec, 4'b0000);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("reset_port%0d", i), port_vec[i], 8'h00);

    $display("[TB] config and route to port1");
    cfgWrite(2'd0, 8'h10);
    cfgWrite(2'd1, 8'h20);
    cfgWrite(2'd2, 8'h30);
    cfgWrite(2'd3, 8'h40);
    pkt.delete();
    pkt.push_back(8'h20); pkt.push_back(8'h01); pkt.push_back(8'h03); pkt.push_back(8'hAA);
    pkt.push_back(8'hBB); pkt.push_back(8'hCC); pkt.push_back(8'h5F);
    applyStimulus();
    checkOutput("route_ready", rdy_vec, 4'b0010);
    drainPorts(4'b0010);
    checkOutput("route_ready_after", rdy_vec, 4'b0000);

    $display("[TB] unmatched DA then port3");
    pkt.delete();
    pkt.push_back(8'h99); pkt.push_back(8'h01); pkt.push_back(8'h01); pkt.push_back(8'hEE);
    applyStimulus();
    checkOutput("drop_ready", rdy_vec, 4'b0000);
    pkt.delete();
    pkt.push_back(8'h40); pkt.push_back(8'h02); pkt.push_back(8'h01); pkt.push_back(8'h77);
    pkt.push_back(8'h12);
    applyStimulus();
    checkOutput("port3_ready", rdy_vec, 4'b1000);
    drainPorts(4'b1000);

    $display("[TB] duplicate addresses");
    cfgWrite(2'd0, 8'h55);
    cfgWrite(2'd2, 8'h55);
    pkt.delete();
    pkt.push_back(8'h55); pkt.push_back(8'h03); pkt.push_back(8'h02); pkt.push_back(8'hA5);
    pkt.push_back(8'h5A); pkt.push_back(8'h0F);
    applyStimulus();
    checkOutput("dup_ready", rdy_vec, 4'b0001);
    drainPorts(4'b0001);

    $display("[TB] concurrent ports 0 and 3");
    pkt.delete();
    pkt.push_back(8'h55); pkt.push_back(8'h04); pkt.push_back(8'h02); pkt.push_back(8'h11);
    pkt.push_back(8'h22); pkt.push_back(8'h33);
    applyStimulus();
    pkt.delete();
    pkt.push_back(8'h40); pkt.push_back(8'h05); pkt.push_back(8'h03); pkt.push_back(8'hD1);
    pkt.push_back(8'hD2); pkt.push_back(8'hD3); pkt.push_back(8'hD4); pkt.push_back(8'hD5);
    applyStimulus();
    checkOutput("conc_ready", rdy_vec, 4'b1001);
    drainPorts(4'b1001);

    $display("[TB] overflow on port2");
    cfgWrite(2'd2, 8'h30);
    pkt.delete();
    pkt.push_back(8'h30);
    for (int i = 1; i < 300; i++) pkt.push_back(8'(i * 7));
    applyStimulus();
    checkOutput("ovf_queued", exp_q[2].size(), FIFO_DEPTH);
    checkOutput("ovf_ready", rdy_vec, 4'b0100);
    drainPorts(4'b0100);
    pkt.delete();
    pkt.push_back(8'h30); pkt.push_back(8'h06); pkt.push_back(8'h01); pkt.push_back(8'h9C);
    pkt.push_back(8'h3E);
    applyStimulus();
    checkOutput("ovf_next_ready", rdy_vec, 4'b0100);
    drainPorts(4'b0100);

    $display("[TB] reset mid-packet");
    pkt.delete();
    pkt.push_back(8'h20); pkt.push_back(8'h07); pkt.push_back(8'h01); pkt.push_back(8'h44);
    applyStimulus();
    checkOutput("pre_reset_ready", rdy_vec, 4'b0010);
    data_status = 1'b1;
    data = 8'h40;
    tick();
    data = 8'h08;
    tick();
    reset = 1'b1;
    data_status = 1'b0;
    data = 8'h00;
    for (int i = 0; i < 4; i++) begin
      exp_q[i].delete();
      tb_addr[i] = 8'h00;
    end
    tick();
    checkOutput("mid_reset_ready", rdy_vec, 4'b0000);
    for (int i = 0; i < 4; i++) checkOutput($sformatf("mid_reset_port%0d", i), port_vec[i], 8'h00);
    reset = 1'b0;
    tick();
    pkt.delete();
    pkt.push_back(8'h20); pkt.push_back(8'h01); pkt.push_back(8'h01); pkt.push_back(8'h66);
    applyStimulus();
    checkOutput("cleared_addr_ready", rdy_vec, 4'b0000);
    pkt.delete();
    pkt.push_back(8'h00); pkt.push_back(8'h11); pkt.push_back(8'h22);
    applyStimulus();
    checkOutput("zero_da_ready", rdy_vec, 4'b0001);
    drainPorts(4'b0001);

    for (int i = 0; i < 4; i++) checkOutput($sformatf("final_q%0d", i), exp_q[i].size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
